// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_t    : controller FSM states (BOOT, IDLE, BUSY, KILL)
//   INSTR_BYTES      : PC increment per sequential fetch
//   RESET_PC_DEFAULT : default first fetch address
//   is_misaligned()  : true when an address is not word aligned
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of every non-clock signal of the fetch controller.
//   execute side : redirect_valid, redirect_pc (into fetch)
//   memory side  : imem_req, imem_addr (out); imem_ack, imem_rdata (in)
//   decode side  : stall (in); instr_valid, instr, instr_pc (out)
//   status       : pc, fetch_fault (out)
//
// Handshakes:
//   memory : imem_req/imem_addr stay asserted and stable from the first
//            request cycle until the cycle imem_ack=1; the read completes in
//            that cycle and imem_rdata is valid only then.
//   decode : the slot (instr/instr_pc) is transferred on a rising edge when
//            instr_valid=1 and stall=0; with stall=1 the slot holds.
// master = the fetch controller, slave = the surrounding pipeline/memory.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             stall;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic [WIDTH-1:0] pc;
  logic             fetch_fault;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, fetch_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, fetch_fault
  );
endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry output slot between fetch and decode.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : capture data_i/pc_i as a new live instruction
//   flush_i  : drop the slot (wins over load_i)
//   stall_i  : decode cannot take the slot this cycle
//   data_i, pc_i           : incoming instruction word and its address
//   valid_o, instr_o, pc_o : slot contents presented to decode
module fetch_out_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      // A load may coincide with decode consuming the old entry.
      valid_d = 1'b1;
      instr_d = data_i;
      pc_d    = pc_i;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC and the request FSM and feeds a
// one-entry slot (fetch_out_buf) towards decode.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : fetch_if master (redirect, memory and decode signals)
//   state_dbg_o : current FSM state, for observation only
//
// If memory answers while the slot is full and decode is stalled, the word
// has nowhere to go: it is dropped and the PC is not advanced, so the same
// address is requested again once the slot drains.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_if.master      bus,
  output fetch_state_t state_dbg_o
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] kill_addr_q, kill_addr_d;
  logic             fault_q, fault_d;

  logic             req;
  logic [WIDTH-1:0] addr;
  logic             load;
  logic             flush;
  logic             slot_valid;
  logic [WIDTH-1:0] slot_instr;
  logic [WIDTH-1:0] slot_pc;
  logic             slot_open;
  logic [WIDTH-1:0] redir_pc_al;

  assign slot_open   = !slot_valid || !bus.stall;
  assign redir_pc_al = {bus.redirect_pc[WIDTH-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    fault_d     = bus.redirect_valid && is_misaligned(bus.redirect_pc[1:0]);
    req         = 1'b0;
    addr        = pc_q;
    load        = 1'b0;
    flush       = 1'b0;

    // Redirect beats ack and stall in every state.
    if (bus.redirect_valid) begin
      pc_d  = redir_pc_al;
      flush = 1'b1;
    end

    case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (!bus.redirect_valid && slot_open) state_d = BUSY;
      end
      BUSY: begin
        req  = 1'b1;
        addr = pc_q;
        if (bus.redirect_valid) begin
          if (bus.imem_ack) begin
            state_d = IDLE;
          end else begin
            // Request cannot be withdrawn; finish it at the old address.
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          if (slot_open) begin
            load    = 1'b1;
            pc_d    = pc_q + WIDTH'(INSTR_BYTES);
            state_d = bus.stall ? IDLE : BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      KILL: begin
        req  = 1'b1;
        addr = kill_addr_q;
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      fault_q     <= fault_d;
    end
  end

  fetch_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .stall_i (bus.stall),
    .data_i  (bus.imem_rdata),
    .pc_i    (pc_q),
    .valid_o (slot_valid),
    .instr_o (slot_instr),
    .pc_o    (slot_pc)
  );

  // Outputs are forced low combinationally for the whole reset window,
  // including the first cycle before any reset edge.
  assign bus.imem_req    = req & ~rst;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = slot_valid & ~rst;
  assign bus.instr       = rst ? '0 : slot_instr;
  assign bus.instr_pc    = rst ? '0 : slot_pc;
  assign bus.pc          = pc_q;
  assign bus.fetch_fault = fault_q & ~rst;
  assign state_dbg_o     = state_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath/address width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 redirect_valid  in  1  branch/jump taken in execute; redirect_pc is valid this cycle.
REQ-005 redirect_pc  in  WIDTH  target address of the redirect.
REQ-006 stall  in  1  decode cannot accept; held instruction must not change.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  WIDTH  read address; equals PC while imem_req=1.
REQ-009 imem_ack  in  1  memory completes the request this cycle; imem_rdata is valid.
REQ-010 imem_rdata  in  WIDTH  fetched instruction word.
REQ-011 instr_valid  out  1  instr/instr_pc hold a live instruction for decode.
REQ-012 instr  out  WIDTH  instruction delivered to decode.
REQ-013 instr_pc  out  WIDTH  address of instr.
REQ-014 PC  out  WIDTH  current fetch address.
REQ-015 fetch_fault  out  1  one-cycle pulse on a misaligned redirect.

Function
REQ-016 The FSM SHALL have states BOOT, IDLE, BUSY and KILL.
REQ-017 BOOT: no request; next cycle goes to IDLE.
REQ-018 IDLE: go to BUSY when the output slot is free or being consumed (!instr_valid || !stall); imem_req rises in BUSY.
REQ-019 BUSY: imem_req=1 and imem_addr=PC, held stable until imem_ack.
REQ-020 BUSY with imem_ack and no redirect: same edge, instr<=imem_rdata, instr_pc<=PC, instr_valid<=1, PC<=PC+4.
REQ-021 After REQ-020, the FSM SHALL stay in BUSY if the slot is free next cycle, else go to IDLE.
REQ-022 Back-to-back acks SHALL deliver one instruction per cycle (zero-wait memory gives throughput 1).
REQ-023 stall=1 with instr_valid=1: instr, instr_pc and instr_valid SHALL hold.
REQ-024 stall=0: the slot is consumed at the edge; instr_valid clears unless refilled on the same edge.
REQ-025 redirect_valid SHALL have the highest priority over ack and stall, in any state.
REQ-026 Redirect: PC<=redirect_pc with bits[1:0] forced to 0, and instr_valid<=0 (flush) on the same edge.
REQ-027 Redirect in BUSY without ack: go to KILL and keep imem_req=1 at the old address until ack, then discard the data.
REQ-028 Redirect in BUSY with ack in the same cycle: discard the data and go to IDLE.
REQ-029 KILL with ack: discard the data and go to IDLE; a further redirect in KILL updates PC and stays in KILL.
REQ-030 redirect_pc[1:0]!=0: fetch_fault=1 for exactly one cycle; the redirect still applies per REQ-026.
REQ-031 PC+4 SHALL wrap modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000) with no flag.
REQ-032 imem_req SHALL never deassert before ack except under rst.

Reset
REQ-033 While rst=1, all registers SHALL be set on the edge: PC=RESET_PC, state=BOOT.
REQ-034 While rst=1, all outputs SHALL be held low: instr_valid=0, instr=0, instr_pc=0, imem_req=0, fetch_fault=0.
REQ-035 rst mid-transaction SHALL abandon the outstanding request; a late ack SHALL be ignored (BOOT/IDLE ignore ack).

Structure
REQ-036 Package fetch_pkg SHALL hold the state enum fetch_state_t, INSTR_BYTES=4 and the RESET_PC default.
REQ-037 The output slot (instr, instr_pc, instr_valid, hold/flush) SHALL be sub-module fetch_out_buf; the FSM and PC stay in fetch_ctrl.

Verification
REQ-038 Reset release, zero-wait ack every cycle: imem_addr sequence 0x0, 0x4, 0x8; instr_valid=1 from the third cycle after release.
REQ-039 stall=1 for 3 cycles while instr_pc=0x8: instr stable and no new imem_req beyond one outstanding; delivery resumes with 0xC after release.
REQ-040 Ack delayed 2 cycles plus redirect to 0x100 in the first wait cycle: state KILL; addr held at the old PC until ack; data dropped; next request at 0x100.
REQ-041 Redirect to 0x202: fetch_fault pulses once; next imem_addr=0x200; instr_valid=0 the cycle after the redirect.
REQ-042 PC=0xFFFF_FFFC with ack: next imem_addr=0x0000_0000.
REQ-043 rst asserted while BUSY, then ack arrives: ack ignored; first post-reset request at RESET_PC.
